// File: rtl/seg7_pkg.sv
// Shared types and the character-to-segment encoding used by the text scroller and the
// display stage. Segment codes are active-low {a,b,c,d,e,f,g,dp}.
package seg7_pkg;

    typedef enum logic [4:0] {
        BLANK = 5'd0,
        D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        A, C, E, F, G, H, L, O, P, U
    } char_code_e;

    typedef enum logic {
        StLoad,
        StScroll
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] char2seg(input char_code_e c);
        logic [7:0] seg;
        case (c)
            D0:      seg = 8'h03;
            D1:      seg = 8'h9F;
            D2:      seg = 8'h25;
            D3:      seg = 8'h0D;
            D4:      seg = 8'h99;
            D5:      seg = 8'h49;
            D6:      seg = 8'h41;
            D7:      seg = 8'h1F;
            D8:      seg = 8'h01;
            D9:      seg = 8'h09;
            A:       seg = 8'h11;
            C:       seg = 8'h63;
            E:       seg = 8'h61;
            F:       seg = 8'h71;
            G:       seg = 8'h43;
            H:       seg = 8'h91;
            L:       seg = 8'hE3;
            O:       seg = 8'h03;
            P:       seg = 8'h31;
            U:       seg = 8'h83;
            // BLANK and every unassigned code stay dark.
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_char_rom.sv
// Combinational character code to active-low segment lookup.
module seg7_char_rom
    import seg7_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [7:0] seg_o
);

    assign seg_o = char2seg(char_code_e'(code_i));

endmodule

// File: rtl/seg7_text_scroller.sv
// Buffers a short message from a valid/ready stream, then scrolls it leftwards across an
// 8-digit display as packed active-low segment codes.
module seg7_text_scroller
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned MSG_DEPTH = 32,
    parameter int unsigned TICK_DIV  = 25_000_000
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [4:0]            char_i,
    input  logic                  char_valid_i,
    input  logic                  char_last_i,
    output logic                  char_ready_o,
    input  logic                  msg_clr_i,
    input  logic                  scroll_en_i,
    output logic [DIGITS*8-1:0]   digits_o,
    output logic                  frame_o
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(MSG_DEPTH + DIGITS) + 1;
    localparam int unsigned TW = $clog2(TICK_DIV);

    state_e               state_q;
    logic [LW-1:0]        len_q;
    logic [AW-1:0]        wr_ptr_q;
    logic [SW-1:0]        start_q;
    logic [TW-1:0]        tick_q;
    logic [4:0]           msg_buf_q [MSG_DEPTH];
    logic [DIGITS*8-1:0]  digits_q;
    logic [DIGITS*8-1:0]  window_seg;

    logic          accept;
    logic          tick_wrap;
    logic [SW-1:0] span;
    logic [SW-1:0] start_last;

    assign char_ready_o = (state_q == StLoad) && !msg_clr_i;
    assign accept       = char_valid_i && char_ready_o;
    assign tick_wrap    = (tick_q == TW'(TICK_DIV - 1));
    assign span         = SW'(len_q) + SW'(DIGITS);
    assign start_last   = span - SW'(1);
    assign frame_o      = (state_q == StScroll) && scroll_en_i && tick_wrap && !msg_clr_i;
    assign digits_o     = digits_q;

    // Digit k shows virtual position start + DIGITS-1-k, wrapped once into [0, len+DIGITS).
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [SW-1:0] idx_raw;
        logic [SW-1:0] idx;
        logic [4:0]    code;

        assign idx_raw = start_q + SW'(DIGITS - 1 - k);
        assign idx     = (idx_raw >= span) ? idx_raw - span : idx_raw;
        assign code    = (idx < SW'(len_q)) ? msg_buf_q[idx[AW-1:0]] : BLANK;

        seg7_char_rom u_rom (
            .code_i (code),
            .seg_o  (window_seg[8*k +: 8])
        );
    end

    // Buffer needs no reset; only positions below len_q are ever displayed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            msg_buf_q[wr_ptr_q] <= char_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= StLoad;
            len_q    <= '0;
            wr_ptr_q <= '0;
            start_q  <= '0;
            tick_q   <= '0;
            digits_q <= '1;
        end else if (msg_clr_i) begin
            state_q  <= StLoad;
            len_q    <= '0;
            wr_ptr_q <= '0;
            start_q  <= '0;
            tick_q   <= '0;
            digits_q <= '1;
        end else begin
            case (state_q)
                StLoad: begin
                    digits_q <= '1;
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        if (char_last_i || wr_ptr_q == AW'(MSG_DEPTH - 1)) begin
                            state_q <= StScroll;
                            len_q   <= LW'(wr_ptr_q) + LW'(1);
                            start_q <= '0;
                            tick_q  <= '0;
                        end
                    end
                end
                StScroll: begin
                    digits_q <= window_seg;
                    if (scroll_en_i) begin
                        if (tick_wrap) begin
                            tick_q  <= '0;
                            start_q <= (start_q == start_last) ? '0 : start_q + SW'(1);
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_text_scroller.sv
// Self-checking bench for seg7_text_scroller: a cycle model of the scroll window feeds a
// scoreboard of expected display images that are popped when the DUT's image changes.
module tb_seg7_text_scroller;

    localparam int unsigned DIGITS    = 8;
    localparam int unsigned MSG_DEPTH = 32;
    localparam int unsigned TICK_DIV  = 4;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [4:0]  char_i;
    logic        char_valid_i;
    logic        char_last_i;
    logic        char_ready_o;
    logic        msg_clr_i;
    logic        scroll_en_i;
    logic [63:0] digits_o;
    logic        frame_o;

    seg7_text_scroller #(
        .DIGITS    (DIGITS),
        .MSG_DEPTH (MSG_DEPTH),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_last_i  (char_last_i),
        .char_ready_o (char_ready_o),
        .msg_clr_i    (msg_clr_i),
        .scroll_en_i  (scroll_en_i),
        .digits_o     (digits_o),
        .frame_o      (frame_o)
    );

    always #5 clk_i = ~clk_i;

    int checks      = 0;
    int errors      = 0;
    int frames_seen = 0;
    int dut_acc     = 0;

    // Reference model state
    logic [4:0]  m_buf[$];
    int          m_len;
    int          m_start;
    int          m_tick;
    int          pop_wait;
    bit          m_scroll;
    logic [63:0] cur_img;
    logic [63:0] sb_q[$];

    function automatic logic [7:0] ref_seg(input logic [4:0] c);
        case (c)
            5'd1:    return 8'h03;
            5'd2:    return 8'h9F;
            5'd3:    return 8'h25;
            5'd4:    return 8'h0D;
            5'd5:    return 8'h99;
            5'd6:    return 8'h49;
            5'd7:    return 8'h41;
            5'd8:    return 8'h1F;
            5'd9:    return 8'h01;
            5'd10:   return 8'h09;
            5'd11:   return 8'h11;
            5'd12:   return 8'h63;
            5'd13:   return 8'h61;
            5'd14:   return 8'h71;
            5'd15:   return 8'h43;
            5'd16:   return 8'h91;
            5'd17:   return 8'hE3;
            5'd18:   return 8'h03;
            5'd19:   return 8'h31;
            5'd20:   return 8'h83;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] exp_image(input int start);
        logic [63:0] img;
        int q;
        for (int k = 0; k < DIGITS; k++) begin
            q = (start + DIGITS - 1 - k) % (m_len + DIGITS);
            img[8*k +: 8] = (q < m_len) ? ref_seg(m_buf[q]) : 8'hFF;
        end
        return img;
    endfunction

    function automatic void model_reset();
        m_buf.delete();
        sb_q.delete();
        m_len    = 0;
        m_start  = 0;
        m_tick   = 0;
        pop_wait = 0;
        m_scroll = 1'b0;
        cur_img  = '1;
    endfunction

    // Called right after each rising edge with the pre-edge model state.
    function automatic void model_edge();
        if (m_scroll && scroll_en_i) begin
            if (m_tick == TICK_DIV - 1) begin
                m_tick  = 0;
                m_start = (m_start == m_len + DIGITS - 1) ? 0 : m_start + 1;
                sb_q.push_back(exp_image(m_start));
                pop_wait = 2;
            end else begin
                m_tick++;
            end
        end
    endfunction

    function automatic void model_negedge();
        if (pop_wait > 0) begin
            pop_wait--;
            if (pop_wait == 0 && sb_q.size() > 0) cur_img = sb_q.pop_front();
        end
    endfunction

    function automatic bit exp_frame();
        return m_scroll && scroll_en_i && (m_tick == TICK_DIV - 1) && !msg_clr_i;
    endfunction

    task automatic apply_reset();
        @(negedge clk_i);
        arstn_i      = 1'b0;
        char_valid_i = 1'b0;
        char_last_i  = 1'b0;
        char_i       = '0;
        msg_clr_i    = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            model_edge();
            @(negedge clk_i);
            model_negedge();
            if (frame_o === 1'b1) frames_seen++;
            checks++;
            if (frame_o !== exp_frame()) begin
                errors++;
                $display("FAIL frame: got %b expected %b (t=%0t)", frame_o, exp_frame(), $time);
            end
            checks++;
            if (digits_o !== cur_img) begin
                errors++;
                $display("FAIL digits: got %h expected %h (t=%0t)", digits_o, cur_img, $time);
            end
        end
    endtask

    task automatic load_chars(input logic [4:0] chars[$], input bit last_final);
        for (int i = 0; i < chars.size(); i++) begin
            bit acc;
            bit last;
            last         = last_final && (i == chars.size() - 1);
            char_i       = chars[i];
            char_valid_i = 1'b1;
            char_last_i  = last;
            acc          = !m_scroll;
            #1;
            checks++;
            if (char_ready_o !== acc) begin
                errors++;
                $display("FAIL ready: got %b expected %b (char %0d)", char_ready_o, acc, i);
            end
            if (char_ready_o === 1'b1) dut_acc++;
            @(posedge clk_i);
            model_edge();
            if (acc) begin
                m_buf.push_back(chars[i]);
                if (last || m_buf.size() == MSG_DEPTH) begin
                    m_scroll = 1'b1;
                    m_len    = m_buf.size();
                    m_start  = 0;
                    m_tick   = 0;
                    sb_q.push_back(exp_image(0));
                    pop_wait = 2;
                end
            end
            @(negedge clk_i);
            model_negedge();
            checks++;
            if (frame_o !== exp_frame()) begin
                errors++;
                $display("FAIL load_frame: got %b expected %b", frame_o, exp_frame());
            end
            checks++;
            if (digits_o !== cur_img) begin
                errors++;
                $display("FAIL load_digits: got %h expected %h", digits_o, cur_img);
            end
        end
        char_valid_i = 1'b0;
        char_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        arstn_i      = 1'b0;
        char_valid_i = 1'b0;
        char_last_i  = 1'b0;
        char_i       = '0;
        msg_clr_i    = 1'b0;
        scroll_en_i  = 1'b1;
        model_reset();
        @(negedge clk_i);
        checks++;
        if (digits_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL reset_digits: got %h expected %h", digits_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checks++;
        if (char_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", char_ready_o);
        end
        checks++;
        if (frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame: got %b expected 0", frame_o);
        end
        arstn_i = 1'b1;
        run_cycles(3);
    endtask

    task automatic test_scroll();
        logic [4:0] msg[$];
        apply_reset();
        scroll_en_i = 1'b1;
        msg = '{5'd14, 5'd19, 5'd15, 5'd11};
        load_chars(msg, 1'b1);
        run_cycles(1);
        checks++;
        if (digits_o !== 64'h7131_4311_FFFF_FFFF) begin
            errors++;
            $display("FAIL first_image: got %h expected %h", digits_o, 64'h7131_4311_FFFF_FFFF);
        end
        frames_seen = 0;
        run_cycles(4);
        checks++;
        if (frames_seen != 1) begin
            errors++;
            $display("FAIL frame_count4: got %0d expected 1", frames_seen);
        end
        checks++;
        if (digits_o[63:56] !== 8'h31) begin
            errors++;
            $display("FAIL digit7_after_pulse: got %h expected 31", digits_o[63:56]);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] msg[$];
        apply_reset();
        scroll_en_i = 1'b1;
        msg = '{5'd14, 5'd19, 5'd15, 5'd11};
        load_chars(msg, 1'b1);
        run_cycles(1);
        frames_seen = 0;
        run_cycles(48);
        checks++;
        if (frames_seen != 12) begin
            errors++;
            $display("FAIL wrap_frames: got %0d expected 12", frames_seen);
        end
        checks++;
        if (digits_o !== 64'h7131_4311_FFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_image: got %h expected %h", digits_o, 64'h7131_4311_FFFF_FFFF);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] msg[$];
        apply_reset();
        scroll_en_i = 1'b1;
        for (int i = 0; i < 40; i++) msg.push_back(5'((i % 20) + 1));
        dut_acc = 0;
        load_chars(msg, 1'b0);
        checks++;
        if (dut_acc != 32) begin
            errors++;
            $display("FAIL overflow_accepted: got %0d expected 32", dut_acc);
        end
        checks++;
        if (char_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_ready: got %b expected 0", char_ready_o);
        end
        // One full revolution of a 32-character message plus eight blank positions.
        run_cycles(164);
    endtask

    task automatic test_freeze();
        logic [4:0] msg[$];
        apply_reset();
        scroll_en_i = 1'b1;
        msg = '{5'd16, 5'd13, 5'd17, 5'd17, 5'd18};
        load_chars(msg, 1'b1);
        run_cycles(6);
        checks++;
        if (digits_o !== 64'h61E3_E303_FFFF_FFFF) begin
            errors++;
            $display("FAIL pre_freeze: got %h expected %h", digits_o, 64'h61E3_E303_FFFF_FFFF);
        end
        scroll_en_i = 1'b0;
        frames_seen = 0;
        run_cycles(10);
        checks++;
        if (frames_seen != 0) begin
            errors++;
            $display("FAIL freeze_frames: got %0d expected 0", frames_seen);
        end
        checks++;
        if (digits_o !== 64'h61E3_E303_FFFF_FFFF) begin
            errors++;
            $display("FAIL freeze_image: got %h expected %h", digits_o, 64'h61E3_E303_FFFF_FFFF);
        end
        scroll_en_i = 1'b1;
        frames_seen = 0;
        run_cycles(1);
        checks++;
        if (frames_seen != 1) begin
            errors++;
            $display("FAIL resume_frame: got %0d expected 1", frames_seen);
        end
        run_cycles(2);
        checks++;
        if (digits_o !== 64'hE3E3_03FF_FFFF_FFFF) begin
            errors++;
            $display("FAIL resume_image: got %h expected %h", digits_o, 64'hE3E3_03FF_FFFF_FFFF);
        end
    endtask

    task automatic test_async_reset();
        run_cycles(3);
        arstn_i = 1'b0;
        #1;
        checks++;
        if (digits_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL async_digits: got %h expected %h", digits_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checks++;
        if (char_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_ready: got %b expected 1", char_ready_o);
        end
        checks++;
        if (frame_o !== 1'b0) begin
            errors++;
            $display("FAIL async_frame: got %b expected 0", frame_o);
        end
        model_reset();
        @(negedge clk_i);
        arstn_i = 1'b1;
    endtask

    task automatic test_clear();
        logic [4:0] msg[$];
        apply_reset();
        scroll_en_i = 1'b1;
        msg = '{5'd12, 5'd11, 5'd14, 5'd13};
        load_chars(msg, 1'b1);
        run_cycles(5);
        while (m_tick == TICK_DIV - 1) run_cycles(1);
        msg_clr_i    = 1'b1;
        char_valid_i = 1'b1;
        char_last_i  = 1'b1;
        char_i       = 5'd12;
        #1;
        checks++;
        if (char_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got %b expected 0", char_ready_o);
        end
        @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        msg_clr_i    = 1'b0;
        char_valid_i = 1'b0;
        char_last_i  = 1'b0;
        #1;
        checks++;
        if (digits_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL clr_digits: got %h expected %h", digits_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checks++;
        if (char_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_load_ready: got %b expected 1", char_ready_o);
        end
        checks++;
        if (frame_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_frame: got %b expected 0", frame_o);
        end
        // Unassigned code 25 must render blank ahead of H.
        msg = '{5'd25, 5'd16};
        load_chars(msg, 1'b1);
        run_cycles(1);
        checks++;
        if (digits_o !== 64'hFF91_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL reload_image: got %h expected %h", digits_o, 64'hFF91_FFFF_FFFF_FFFF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scroll();
        test_wrap();
        test_overflow();
        test_freeze();
        test_async_reset();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
